// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - three-digit multiplexed seven-segment driver with leading-zero blanking
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        disp_en,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        digit_err
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [11:0]   hold;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    sel_digit;
  logic          sel_blank;
  logic [2:0]    sel_an;

  function automatic logic nib_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  // Active-low gfedcba patterns; any non-decimal nibble shows 'E'
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h06;
    endcase
  endfunction

  // Capture the BCD word and flag any out-of-range nibble on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold      <= 12'h000;
      digit_err <= 1'b0;
    end else if (bcd_valid) begin
      hold      <= bcd_in;
      digit_err <= nib_bad(bcd_in[11:8]) | nib_bad(bcd_in[7:4]) | nib_bad(bcd_in[3:0]);
    end
  end

  // Prescaler and digit index; both parked at zero while the display is off
  always_ff @(posedge clk) begin
    if (!rst_n || !disp_en) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Select the current digit, its anode and whether it is a blanked leading zero
  always_comb begin
    sel_digit = hold[3:0];
    sel_blank = 1'b0;
    sel_an    = 3'b110;
    case (idx)
      2'd1: begin
        sel_digit = hold[7:4];
        sel_blank = (BLANK_LZ != 0) && (hold[11:4] == 8'h00);
        sel_an    = 3'b101;
      end
      2'd2: begin
        sel_digit = hold[11:8];
        sel_blank = (BLANK_LZ != 0) && (hold[11:8] == 4'h0);
        sel_an    = 3'b011;
      end
      default: ;
    endcase
  end

  // Register the drive so anodes and segments switch together, one cycle behind the index
  always_ff @(posedge clk) begin
    if (!rst_n || !disp_en || sel_blank) begin
      an  <= 3'b111;
      seg <= 7'h7F;
    end else begin
      an  <= sel_an;
      seg <= seg_decode(sel_digit);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        bcd_valid;
  logic        disp_en;
  logic [2:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        digit_err, digit_err_nb;

  int n_pass  = 0;
  int n_total = 0;

  seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .disp_en(disp_en), .an(an), .seg(seg), .digit_err(digit_err)
  );

  seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .disp_en(disp_en), .an(an_nb), .seg(seg_nb), .digit_err(digit_err_nb)
  );

  always #5 clk = ~clk;

  // Reference model: time since enable, held word, expected drive
  logic [6:0]  seg_lut [16];
  int          m_cnt;
  logic [11:0] m_hold;
  logic        m_err;
  logic [9:0]  exp_bl, exp_nb;

  function automatic logic [9:0] ref_disp(input logic [11:0] h, input int slot, input bit blank);
    logic [3:0] nib;
    logic [2:0] a;
    bit         blanked;
    nib = (slot == 0) ? h[3:0] : (slot == 1) ? h[7:4] : h[11:8];
    blanked = blank && (((slot == 2) && (h[11:8] == 4'h0)) || ((slot == 1) && (h[11:4] == 8'h00)));
    if (blanked) return {3'b111, 7'h7F};
    a = 3'b111 & ~(3'b001 << slot);
    return {a, seg_lut[nib]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic e, input logic [11:0] b);
    int slot;
    rst_n = r; bcd_valid = v; disp_en = e; bcd_in = b;
    if (!r) begin
      m_hold = 12'h000; m_err = 1'b0; m_cnt = 0;
      exp_bl = {3'b111, 7'h7F}; exp_nb = {3'b111, 7'h7F};
    end else begin
      if (e) begin
        slot   = (m_cnt / RD) % 3;
        exp_bl = ref_disp(m_hold, slot, 1'b1);
        exp_nb = ref_disp(m_hold, slot, 1'b0);
        m_cnt  = (m_cnt + 1) % (3 * RD);
      end else begin
        exp_bl = {3'b111, 7'h7F}; exp_nb = {3'b111, 7'h7F};
        m_cnt  = 0;
      end
      if (v) begin
        m_hold = b;
        m_err  = (b[3:0] > 4'd9) || (b[7:4] > 4'd9) || (b[11:8] > 4'd9);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Capture with display off, then check 24 cycles of scan on both variants
  task automatic scan_check(input string name, input logic [11:0] b, input logic exp_err,
                            input logic [2:0][2:0] ea, input logic [2:0][6:0] es,
                            input logic [2:0][2:0] na, input logic [2:0][6:0] ns);
    int s;
    step(1'b1, 1'b1, 1'b0, b);
    check({name, "_err"}, 16'(digit_err), 16'(exp_err));
    check({name, "_off"}, {an, seg}, {3'b111, 7'h7F});
    for (int i = 0; i < 6 * RD; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'h000);
      s = (i / RD) % 3;
      check({name, "_blz"}, {an, seg}, {ea[s], es[s]});
      check({name, "_nolz"}, {an_nb, seg_nb}, {na[s], ns[s]});
    end
  endtask

  typedef struct {
    logic        r, v, e;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 12'h0A3, 3'b111, 7'h7F, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 12'h000, 3'b110, 7'h40, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 12'h0A3, 3'b111, 7'h7F, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 12'h555, 3'b110, 7'h30, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 12'h0F0, 3'b111, 7'h7F, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 12'h999, 3'b111, 7'h7F, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 12'h123, 3'b110, 7'h10, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 12'h00E, 3'b111, 7'h7F, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 12'h000, 3'b110, 7'h06, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 12'h456, 3'b111, 7'h7F, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 12'h000, 3'b110, 7'h40, 1'b0};

    rst_n = 1'b0; bcd_valid = 1'b0; disp_en = 1'b0; bcd_in = 12'h000;
    m_cnt = 0; m_hold = 12'h000; m_err = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].e, vecs[i].bcd);
      check($sformatf("vec%0d_an", i), 16'(an), 16'(vecs[i].an));
      check($sformatf("vec%0d_seg", i), 16'(seg), 16'(vecs[i].seg));
      check($sformatf("vec%0d_err", i), 16'(digit_err), 16'(vecs[i].err));
    end

    // Slot arrays are indexed [hundreds, tens, units] = [2,1,0]
    scan_check("scan255", 12'h255, 1'b0, {3'b011, 3'b101, 3'b110}, {7'h24, 7'h12, 7'h12},
                                        {3'b011, 3'b101, 3'b110}, {7'h24, 7'h12, 7'h12});
    scan_check("lz007",   12'h007, 1'b0, {3'b111, 3'b111, 3'b110}, {7'h7F, 7'h7F, 7'h78},
                                        {3'b011, 3'b101, 3'b110}, {7'h40, 7'h40, 7'h78});
    scan_check("zero000", 12'h000, 1'b0, {3'b111, 3'b111, 3'b110}, {7'h7F, 7'h7F, 7'h40},
                                        {3'b011, 3'b101, 3'b110}, {7'h40, 7'h40, 7'h40});
    scan_check("err0A3",  12'h0A3, 1'b1, {3'b111, 3'b101, 3'b110}, {7'h7F, 7'h06, 7'h30},
                                        {3'b011, 3'b101, 3'b110}, {7'h40, 7'h06, 7'h30});

    // Enable dropped for 3 cycles in the middle of the hundreds slot
    step(1'b1, 1'b1, 1'b0, 12'h255);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 12'h000);
    check("tog_hund", {an, seg}, {3'b011, 7'h24});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 12'h000);
      check("tog_off", {an, seg}, {3'b111, 7'h7F});
    end
    for (int i = 0; i < RD; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'h000);
      check("tog_units", {an, seg}, {3'b110, 7'h12});
    end
    step(1'b1, 1'b0, 1'b1, 12'h000);
    check("tog_tens", {an, seg}, {3'b101, 7'h12});

    // Capture on the slot change, then a mid-slot capture
    step(1'b1, 1'b1, 1'b0, 12'h255);
    for (int i = 0; i < RD; i++) step(1'b1, 1'b0, 1'b1, 12'h000);
    step(1'b1, 1'b1, 1'b1, 12'h137);
    check("edge_old", {an, seg}, {3'b101, 7'h12});
    step(1'b1, 1'b0, 1'b1, 12'h000);
    check("edge_new", {an, seg}, {3'b101, 7'h30});
    step(1'b1, 1'b1, 1'b1, 12'h188);
    check("mid_old", {an, seg}, {3'b101, 7'h30});
    step(1'b1, 1'b0, 1'b1, 12'h000);
    check("mid_new", {an, seg}, {3'b101, 7'h00});
    step(1'b1, 1'b0, 1'b1, 12'h000);
    check("mid_hund", {an, seg}, {3'b011, 7'h79});

    // Reset in the middle of the tens slot while showing 199
    step(1'b1, 1'b1, 1'b0, 12'h199);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 12'h000);
    check("rst_pre", {an, seg}, {3'b101, 7'h10});
    step(1'b0, 1'b1, 1'b1, 12'hAAA);
    check("rst_out", {an, seg}, {3'b111, 7'h7F});
    check("rst_err", 16'(digit_err), 16'h0000);
    step(1'b1, 1'b0, 1'b1, 12'h000);
    check("rst_units", {an, seg}, {3'b110, 7'h40});

    // Randomized traffic against the reference model
    step(1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 600; i++) begin
      logic [11:0] b;
      b = 12'($urandom);
      if ($urandom_range(0, 2) != 0)
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) b[11:4] = 8'h00;
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) != 0), b);
      check("rnd_blz", {an, seg}, exp_bl);
      check("rnd_nolz", {an_nb, seg_nb}, exp_nb);
      check("rnd_err", {digit_err_nb, digit_err}, {m_err, m_err});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
